// File: rtl/uart_rx_os16_if.sv
// rtl/uart_rx_os16_if.sv - serial line and received-byte bundle for uart_rx_os16
// slave: the receiver; master: the line driver / byte consumer.
interface uart_rx_os16_if;
  logic       iRX;
  logic [7:0] oDATA;
  logic       oVALID;
  logic       oFRAME_ERR;
  logic       oBUSY;

  modport slave  (input iRX, output oDATA, output oVALID, output oFRAME_ERR, output oBUSY);
  modport master (output iRX, input oDATA, input oVALID, input oFRAME_ERR, input oBUSY);
endinterface

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling 8N1 UART receiver with 2-of-3 majority voting
// Bytes leave as a one-clock oVALID strobe; a low stop bit gives oFRAME_ERR and parks in BREAK.
module uart_rx_os16 #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int TICK_DIV = CLK_HZ / (BAUD * 16)
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_os16_if.slave bus
);

  localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_rxs;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_s;
  logic             r_smp7;
  logic             r_smp8;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_busy;

  logic             w_in_frame;
  logic             w_tick;
  logic             w_decide;
  logic             w_bit;
  logic             w_start_det;
  logic             w_shift_en;
  logic             w_valid_nxt;
  logic             w_ferr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= bus.iRX;
      r_rxs   <= r_sync1;
    end
  end

  assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign w_tick     = (r_div == DIV_LAST);
  assign w_decide   = w_tick && (r_s == 4'd9);
  assign w_bit      = (r_smp7 & r_smp8) | (r_smp7 & r_rxs) | (r_smp8 & r_rxs);

  // Divider only runs inside a frame, so every frame starts from a zero phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_s   <= 4'd0;
    end else if (w_start_det || !w_in_frame) begin
      r_div <= '0;
      r_s   <= 4'd0;
    end else if (w_tick) begin
      r_div <= '0;
      r_s   <= r_s + 4'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_smp7 <= 1'b1;
      r_smp8 <= 1'b1;
    end else if (w_tick && w_in_frame) begin
      if (r_s == 4'd7) r_smp7 <= r_rxs;
      if (r_s == 4'd8) r_smp8 <= r_rxs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_det = 1'b0;
    w_shift_en  = 1'b0;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = S_START;
          w_start_det = 1'b1;
        end
      end
      S_START: begin
        if (w_decide) w_state_nxt = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_decide) begin
          w_shift_en = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      // Leaving mid stop bit lets a back-to-back start edge be caught.
      S_STOP: begin
        if (w_decide) begin
          if (w_bit) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else if (w_start_det) begin
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else if (w_shift_en) begin
      r_idx          <= r_idx + 3'd1;
      r_shift[r_idx] <= w_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_valid_nxt) r_data <= r_shift;
    end
  end

  assign bus.oDATA      = r_data;
  assign bus.oVALID     = r_valid;
  assign bus.oFRAME_ERR = r_ferr;
  assign bus.oBUSY      = r_busy;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - table-driven scoreboard bench for uart_rx_os16
module tb_uart_rx_os16;

  localparam int BIT_CLKS = 160;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    int         t0;
    bit         lat_chk;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    int         bc;
    int         g_from;
    int         g_to;
    int         gap;
    logic       exp_ferr;
    logic [7:0] exp_data;
    bit         lat_chk;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  vec_t vecs[6];

  uart_rx_os16_if bus();

  uart_rx_os16 #(.CLK_HZ(1_600_000), .BAUD(10_000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every strobe is matched against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!reset && (bus.oVALID || bus.oFRAME_ERR)) begin
      n_cmp++;
      if (bus.oVALID && bus.oFRAME_ERR) begin
        n_err++;
        $display("FAIL strobe_excl: oVALID and oFRAME_ERR both high");
      end
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%0h", bus.oVALID, bus.oFRAME_ERR, bus.oDATA);
      end else begin
        e = sb.pop_front();
        if (bus.oFRAME_ERR !== e.ferr || bus.oDATA !== e.data) begin
          n_err++;
          $display("FAIL strobe: got ferr=%0b data=%0h expected ferr=%0b data=%0h",
                   bus.oFRAME_ERR, bus.oDATA, e.ferr, e.data);
        end
        if (e.lat_chk) begin
          lat = cyc - e.t0;
          n_cmp++;
          if (lat < 1541 || lat > 1545) begin
            n_err++;
            $display("FAIL latency: got %0d clks expected 1541..1545", lat);
          end
        end
      end
    end
  end

  task automatic line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.iRX = v;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_v, input int bc,
                             input int c_from, input int c_to, input int g_from, input int g_to,
                             input bit push, input logic e_ferr, input logic [7:0] e_data,
                             input bit lat);
    int   bi;
    logic v;
    exp_t e;
    for (int c = c_from; c < c_to; c++) begin
      @(negedge clk);
      bi = c / bc;
      if (bi == 0)      v = 1'b0;
      else if (bi <= 8) v = b[bi-1];
      else              v = stop_v;
      if (c >= g_from && c < g_to) v = ~v;
      if (c > 0 && bi <= 8 && (c % bc) == 80) chk("busy_in_frame", 32'(bus.oBUSY), 32'd1);
      if (c == 0 && push) begin
        e.ferr    = e_ferr;
        e.data    = e_data;
        e.t0      = cyc;
        e.lat_chk = lat;
        sb.push_back(e);
      end
      bus.iRX = v;
    end
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("pending_strobes", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_oDATA"}, 32'(bus.oDATA), 32'h00);
    chk({tag, "_oVALID"}, 32'(bus.oVALID), 32'd0);
    chk({tag, "_oFRAME_ERR"}, 32'(bus.oFRAME_ERR), 32'd0);
    chk({tag, "_oBUSY"}, 32'(bus.oBUSY), 32'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    bus.iRX = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    line(1'b1, 30);

    // Bit periods 155/165 are the -3%/+3% rate mismatch cases.
    vecs[0] = '{8'h55, 1'b1, 160,  -1,  -1, 40, 1'b0, 8'h55, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 160,  -1,  -1,  0, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 160,  -1,  -1, 40, 1'b0, 8'h3C, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 160, 565, 575, 40, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 155,  -1,  -1, 40, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h6B, 1'b1, 165,  -1,  -1, 40, 1'b0, 8'h6B, 1'b0};

    for (int i = 0; i < 6; i++) begin
      drive_frame(vecs[i].data, vecs[i].stop_v, vecs[i].bc, 0, 10 * vecs[i].bc,
                  vecs[i].g_from, vecs[i].g_to, 1'b1, vecs[i].exp_ferr, vecs[i].exp_data,
                  vecs[i].lat_chk);
      line(1'b1, vecs[i].gap);
    end
    wait_drain(200);

    // Short low glitch from idle: false start, no strobe.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 20) chk("glitch_busy_high", 32'(bus.oBUSY), 32'd1);
      bus.iRX = 1'b0;
    end
    line(1'b1, 200);
    chk("glitch_busy_low", 32'(bus.oBUSY), 32'd0);
    chk("glitch_data_kept", 32'(bus.oDATA), 32'h6B);

    // Low stop bit, then a 500-clk break that must not start a frame.
    drive_frame(8'h81, 1'b0, BIT_CLKS, 0, 10 * BIT_CLKS, -1, -1, 1'b1, 1'b1, 8'h6B, 1'b1);
    line(1'b0, 500);
    chk("break_busy", 32'(bus.oBUSY), 32'd1);
    chk("break_data_kept", 32'(bus.oDATA), 32'h6B);
    chk("break_no_extra", 32'(sb.size()), 32'd0);
    line(1'b1, 20);
    chk("break_exit_idle", 32'(bus.oBUSY), 32'd0);
    drive_frame(8'h42, 1'b1, BIT_CLKS, 0, 10 * BIT_CLKS, -1, -1, 1'b1, 1'b0, 8'h42, 1'b1);
    line(1'b1, 40);
    wait_drain(200);

    // Reset in the middle of bit 4 discards the partial byte.
    drive_frame(8'hF0, 1'b1, BIT_CLKS, 0, 5 * BIT_CLKS + 80, -1, -1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    bus.iRX = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    line(1'b1, 30);
    chk("after_reset_idle", 32'(bus.oBUSY), 32'd0);
    drive_frame(8'h0F, 1'b1, BIT_CLKS, 0, 10 * BIT_CLKS, -1, -1, 1'b1, 1'b0, 8'h0F, 1'b1);
    line(1'b1, 40);
    wait_drain(200);
    chk("final_data", 32'(bus.oDATA), 32'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
